// File: rtl/cam_dma_pkg.sv
// Shared types for the camera-to-memory frame writer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: frame-sequencer and burst-writer state enums, memory word width.
package cam_dma_pkg;

  localparam int CAM_WORD_W = 32;

  typedef enum logic [1:0] {
    F_OFF    = 2'd0,
    F_ACTIVE = 2'd1,
    F_DRAIN  = 2'd2
  } frame_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_DATA = 2'd2
  } wr_state_e;

endpackage

// File: rtl/cam_dma_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// Latency: a pushed word is visible at head_dat_o one cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
// Ports: push_vld_i/push_dat_i write side, pop_i read side, head_dat_o current
// head, full_o/empty_o flags, level_o word count (0..DEPTH).
module cam_dma_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full_o     = (level_q == LVL_FULL);
  assign empty_o    = (level_q == '0);
  assign do_push    = push_vld_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      // Simultaneous push and pop leave the level unchanged.
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/cam_dma_ctrl.sv
// Camera byte stream -> 32-bit words -> burst writes into one or two frame buffers.
// Latency: word at FIFO head 1 cycle after its 4th byte; mem_req 1 cycle after level threshold.
// Backpressure: none toward the camera; a word arriving at a full FIFO is dropped and flags overflow.
// Ports: cfg_* frame setup, pix_*/frame_start/frame_end camera side, mem_* burst write port,
// busy/frame_done/buf_sel/frame_words/overflow status. Optional CAM_DMA_PINGPONG_EN alternates
// frame buffers; without it every frame goes to cfg_base0 and buf_sel stays 0.
module cam_dma_ctrl
  import cam_dma_pkg::*;
#(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_en,
  input  logic [ADDR_W-1:0]     cfg_base0,
  input  logic [ADDR_W-1:0]     cfg_base1,
  input  logic                  pix_valid,
  input  logic [7:0]            pix_data,
  input  logic                  frame_start,
  input  logic                  frame_end,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [7:0]            mem_len,
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  output logic [CAM_WORD_W-1:0] mem_wdata,
  output logic                  mem_wlast,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  buf_sel,
  output logic [23:0]           frame_words,
  output logic                  overflow
);

  localparam int          LW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] BURST_LVL = LW'(BURST_LEN);

  frame_state_e f_state_q, f_state_d;
  wr_state_e    w_state_q, w_state_d;

  logic [1:0]            byte_idx_q, next_idx;
  logic [CAM_WORD_W-1:0] pack_q, pack_word, head_dat;
  logic [23:0]           word_cnt_q, frame_words_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [7:0]            len_q, len_d, beat_q;
  logic                  overflow_q, frame_done_q, buf_sel_q;
  logic                  cur_buf;
  logic                  take_byte, push_req, frame_go, drain_done, beat_done;
  logic                  fifo_full, fifo_empty;
  logic [LW-1:0]         level;

  cam_dma_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CAM_WORD_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_vld_i (push_req),
    .push_dat_i (pack_word),
    .pop_i      (beat_done),
    .head_dat_o (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (level)
  );

  // Packer: the incoming byte is merged combinationally so a completed (or
  // flushed partial) word is pushed on the same edge that accepts its last byte.
  always_comb begin
    take_byte = (f_state_q == F_ACTIVE) && pix_valid;
    next_idx  = byte_idx_q + 2'(take_byte);
    pack_word = pack_q;
    if (take_byte) pack_word[{byte_idx_q, 3'b000} +: 8] = pix_data;
    push_req  = (f_state_q == F_ACTIVE) &&
                ((take_byte && (byte_idx_q == 2'd3)) || (frame_end && (next_idx != 2'd0)));
  end

  // Frame sequencer.
  always_comb begin
    frame_go   = (f_state_q == F_OFF) && frame_start && cfg_en;
    drain_done = (f_state_q == F_DRAIN) && fifo_empty && (w_state_q == W_IDLE);
    f_state_d  = f_state_q;
    case (f_state_q)
      F_OFF:    if (frame_go)   f_state_d = F_ACTIVE;
      F_ACTIVE: if (frame_end)  f_state_d = F_DRAIN;
      F_DRAIN:  if (drain_done) f_state_d = F_OFF;
      default:                  f_state_d = F_OFF;
    endcase
  end

  // Burst writer. Full bursts whenever enough data is queued; once the frame
  // has ended, whatever remains goes out as one short burst.
  always_comb begin
    w_state_d = w_state_q;
    len_d     = len_q;
    beat_done = (w_state_q == W_DATA) && mem_wready;
    case (w_state_q)
      W_IDLE: begin
        if (level >= BURST_LVL) begin
          w_state_d = W_REQ;
          len_d     = 8'(BURST_LEN - 1);
        end else if ((f_state_q == F_DRAIN) && (level != '0)) begin
          w_state_d = W_REQ;
          len_d     = 8'(level - LW'(1));
        end
      end
      W_REQ:   if (mem_gnt) w_state_d = W_DATA;
      W_DATA:  if (beat_done && (beat_q == len_q)) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  assign mem_req     = (w_state_q == W_REQ);
  assign mem_wvalid  = (w_state_q == W_DATA);
  assign mem_wdata   = mem_wvalid ? head_dat : '0;
  assign mem_wlast   = mem_wvalid && (beat_q == len_q);
  assign mem_addr    = addr_q;
  assign mem_len     = len_q;
  assign busy        = (f_state_q != F_OFF);
  assign frame_done  = frame_done_q;
  assign buf_sel     = buf_sel_q;
  assign frame_words = frame_words_q;
  assign overflow    = overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      f_state_q     <= F_OFF;
      w_state_q     <= W_IDLE;
      byte_idx_q    <= '0;
      pack_q        <= '0;
      word_cnt_q    <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      overflow_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      buf_sel_q     <= 1'b0;
      frame_words_q <= '0;
    end else begin
      f_state_q    <= f_state_d;
      w_state_q    <= w_state_d;
      len_q        <= len_d;
      frame_done_q <= drain_done;

      if (frame_go) begin
        byte_idx_q <= '0;
        pack_q     <= '0;
        word_cnt_q <= '0;
        overflow_q <= 1'b0;
        addr_q     <= cur_buf ? cfg_base1 : cfg_base0;
      end else begin
        // pack_q is cleared after every push so a flushed partial word is zero-padded.
        if (push_req) begin
          byte_idx_q <= '0;
          pack_q     <= '0;
          if (fifo_full) overflow_q <= 1'b1;
          else           word_cnt_q <= word_cnt_q + 24'd1;
        end else if (take_byte) begin
          byte_idx_q <= next_idx;
          pack_q     <= pack_word;
        end
        if (beat_done && mem_wlast)
          addr_q <= addr_q + ((ADDR_W'(len_q) + ADDR_W'(1)) << 2);
      end

      if (w_state_q != W_DATA) beat_q <= '0;
      else if (beat_done)      beat_q <= beat_q + 8'd1;

      if (drain_done) begin
        buf_sel_q     <= cur_buf;
        frame_words_q <= word_cnt_q;
      end
    end
  end

`ifdef CAM_DMA_PINGPONG_EN
  logic cur_buf_q;
  always_ff @(posedge clk) begin
    if (rst)             cur_buf_q <= 1'b0;
    else if (drain_done) cur_buf_q <= ~cur_buf_q;
  end
  assign cur_buf = cur_buf_q;
`else
  assign cur_buf = 1'b0;
`endif

endmodule

// File: tb/tb_cam_dma_ctrl.sv
// Self-checking bench for cam_dma_ctrl: directed frames plus randomized frames
// against a frame-level reference (bytes -> expected words, addresses, burst sizes).
// Honours CAM_DMA_PINGPONG_EN when the design is built with it.
`timescale 1ns/1ps
module tb_cam_dma_ctrl;

  localparam int BURST_LEN  = 8;
  localparam int FIFO_DEPTH = 32;
  localparam int ADDR_W     = 32;
`ifdef CAM_DMA_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_en;
  logic [ADDR_W-1:0] cfg_base0, cfg_base1;
  logic              pix_valid;
  logic [7:0]        pix_data;
  logic              frame_start, frame_end;
  logic              mem_req, mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_len;
  logic              mem_wvalid, mem_wready, mem_wlast;
  logic [31:0]       mem_wdata;
  logic              busy, frame_done, buf_sel, overflow;
  logic [23:0]       frame_words;

  cam_dma_ctrl #(.BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_base0(cfg_base0), .cfg_base1(cfg_base1),
    .pix_valid(pix_valid), .pix_data(pix_data), .frame_start(frame_start), .frame_end(frame_end),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata), .mem_wlast(mem_wlast),
    .busy(busy), .frame_done(frame_done), .buf_sel(buf_sel), .frame_words(frame_words),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: words still owed to memory for the current frame, in order.
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr = '0;
  int          frame_rem = 0;
  int          nframes = 0;
  bit          sb_on = 1'b1;
  int          hs_mode = 0;

  int          cur_len = 0, beat_i = 0;
  bit          prev_wait = 0, prev_stall = 0, prev_gnt = 0, prev_last = 0;
  logic [31:0] prev_addr, prev_wdata;
  logic [7:0]  prev_len;
  logic        prev_wlast;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs_zero(input string pfx);
    chk({pfx, "_req"},    mem_req,     0);
    chk({pfx, "_addr"},   mem_addr,    0);
    chk({pfx, "_len"},    mem_len,     0);
    chk({pfx, "_wvalid"}, mem_wvalid,  0);
    chk({pfx, "_wdata"},  mem_wdata,   0);
    chk({pfx, "_wlast"},  mem_wlast,   0);
    chk({pfx, "_busy"},   busy,        0);
    chk({pfx, "_done"},   frame_done,  0);
    chk({pfx, "_bufsel"}, buf_sel,     0);
    chk({pfx, "_words"},  frame_words, 0);
    chk({pfx, "_ovf"},    overflow,    0);
  endtask

  // One clock: wait past the edge, then drive the memory-side handshakes.
  task automatic tick();
    @(posedge clk);
    #1;
    case (hs_mode)
      0:       begin mem_gnt = 1'b1; mem_wready = 1'b1; end
      1:       begin mem_gnt = ($urandom_range(3) != 0); mem_wready = ($urandom_range(3) != 0); end
      2:       begin mem_gnt = 1'b1; mem_wready = ~mem_wready; end
      default: begin mem_gnt = 1'b0; mem_wready = 1'b1; end
    endcase
  endtask

  // Memory-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst || !sb_on) begin
      prev_wait = 0; prev_stall = 0; prev_gnt = 0; prev_last = 0;
    end else begin
      if (prev_wait && mem_req) begin
        chk("req_addr_hold", mem_addr, prev_addr);
        chk("req_len_hold", mem_len, prev_len);
      end
      if (prev_stall) begin
        chk("stall_wvalid", mem_wvalid, 1);
        chk("stall_wdata", mem_wdata, prev_wdata);
        chk("stall_wlast", mem_wlast, prev_wlast);
      end
      if (prev_gnt)  chk("data_after_gnt", mem_wvalid, 1);
      if (prev_last) chk("gap_after_last", mem_req, 0);
      if (mem_req && mem_gnt) begin
        chk("burst_expected", frame_rem > 0, 1);
        chk("burst_addr", mem_addr, exp_addr);
        chk("burst_len", mem_len, 8'(((frame_rem >= BURST_LEN) ? BURST_LEN : frame_rem) - 1));
        cur_len = int'(mem_len);
        beat_i  = 0;
      end
      if (mem_wvalid && mem_wready) begin
        chk("wlast", mem_wlast, beat_i == cur_len);
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("wdata", mem_wdata, exp_q.pop_front());
        beat_i++;
        exp_addr = exp_addr + 32'd4;
        if (frame_rem > 0) frame_rem--;
      end
      prev_wait  = mem_req && !mem_gnt;
      prev_gnt   = mem_req && mem_gnt;
      prev_stall = mem_wvalid && !mem_wready;
      prev_last  = mem_wvalid && mem_wready && mem_wlast;
      prev_addr  = mem_addr;
      prev_len   = mem_len;
      prev_wdata = mem_wdata;
      prev_wlast = mem_wlast;
    end
  end

  // Sends one frame and checks its completion. Only the first max_words words
  // can be written when the memory side is held off for the whole frame.
  task automatic run_frame(input int nbytes, input bit seq_data, input int gap_pct,
                           input bit dup_start, input int max_words, input int drain_mode);
    logic [7:0]  bytes[$];
    logic [31:0] w;
    int nw, keep, cnt, i;
    for (int k = 0; k < nbytes; k++) bytes.push_back(seq_data ? 8'(k) : 8'($urandom));
    nw   = (nbytes + 3) / 4;
    keep = (nw > max_words) ? max_words : nw;
    for (int k = 0; k < keep; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++)
        if (4*k + j < nbytes) w = w | (32'(bytes[4*k + j]) << (8*j));
      exp_q.push_back(w);
    end
    exp_addr  = (PP && (nframes % 2 == 1)) ? cfg_base1 : cfg_base0;
    frame_rem = keep;

    cfg_en = 1'b1; frame_start = 1'b1; pix_valid = 1'b0; frame_end = 1'b0;
    tick();
    frame_start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ovf_clear", overflow, 0);

    i = 0;
    while (i < nbytes) begin
      pix_valid   = ($urandom_range(99) >= gap_pct);
      pix_data    = pix_valid ? bytes[i] : 8'($urandom);
      frame_start = dup_start && ($urandom_range(15) == 0);
      frame_end   = 1'b0;
      if (pix_valid) begin
        i++;
        if (i == nbytes && $urandom_range(1) == 1) frame_end = 1'b1;
      end
      tick();
    end
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    if (!frame_end) begin
      frame_end = 1'b1;
      tick();
    end
    frame_end = 1'b0;
    hs_mode   = drain_mode;

    cnt = 0;
    while (frame_done !== 1'b1 && cnt < 4000) begin
      tick();
      cnt++;
    end
    chk("done_seen", frame_done, 1);
    chk("frame_words", frame_words, keep);
    chk("buf_sel", buf_sel, PP ? (nframes % 2) : 0);
    chk("overflow", overflow, nw > max_words);
    chk("busy_at_done", busy, 0);
    chk("words_left", exp_q.size(), 0);
    exp_q.delete();
    frame_rem = 0;
    nframes++;
    tick();
    chk("done_pulse", frame_done, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, i;
    rst = 1'b1; cfg_en = 1'b0; cfg_base0 = 32'h1000; cfg_base1 = 32'h8000;
    pix_valid = 1'b0; pix_data = '0; frame_start = 1'b0; frame_end = 1'b0;
    mem_gnt = 1'b0; mem_wready = 1'b0;
    repeat (3) tick();
    chk_outs_zero("reset");
    rst = 1'b0;
    tick();

    // 64-byte frame, two full bursts; then a 10-byte frame with a 3-beat drain burst.
    hs_mode = 0;
    run_frame(64, 1'b1, 0, 1'b0, 1000, 0);
    run_frame(10, 1'b1, 0, 1'b0, 1000, 0);

    // Capture disabled: a frame_start must not start anything.
    cfg_en = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("off_busy", busy, 0);
    for (int k = 0; k < 8; k++) begin
      pix_valid = 1'b1; pix_data = 8'(k);
      tick();
    end
    pix_valid = 1'b0; frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    repeat (20) tick();
    chk("off_busy_after", busy, 0);
    cfg_en = 1'b1;

    // Write-ready toggling every other cycle.
    hs_mode = 2;
    run_frame(40, 1'b1, 0, 1'b0, 1000, 2);

    // Grant withheld for the whole 256-byte stream: only a FIFO's worth survives.
    hs_mode = 3;
    run_frame(256, 1'b1, 0, 1'b0, FIFO_DEPTH, 0);
    hs_mode = 0;
    run_frame(12, 1'b1, 0, 1'b0, 1000, 0);

    // Randomized frames: sizes, gaps, handshake stalls, stray frame_start pulses.
    for (int r = 0; r < 10; r++) begin
      hs_mode = int'($urandom_range(2));
      run_frame(int'($urandom_range(200, 1)), 1'b0, int'($urandom_range(60)), 1'b1, 1000, hs_mode);
    end

    // Address wrap-around at the top of the address space.
    cfg_base0 = 32'hFFFF_FFF0; cfg_base1 = 32'hFFFF_FFE0;
    hs_mode = 1;
    run_frame(48, 1'b0, 20, 1'b0, 1000, 1);
    run_frame(44, 1'b0, 20, 1'b0, 1000, 1);

    // Reset in the middle of a burst, then a clean frame from buffer 0.
    cfg_base0 = 32'h1000; cfg_base1 = 32'h8000;
    hs_mode = 0;
    sb_on = 1'b0;
    cfg_en = 1'b1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cnt = 0; i = 0;
    while (mem_wvalid !== 1'b1 && cnt < 200) begin
      pix_valid = 1'b1; pix_data = 8'(i); i++;
      tick();
      cnt++;
    end
    chk("rst_burst_seen", mem_wvalid, 1);
    pix_valid = 1'b0; rst = 1'b1;
    tick();
    chk_outs_zero("midrst");
    rst = 1'b0;
    exp_q.delete(); frame_rem = 0; nframes = 0;
    sb_on = 1'b1;
    tick();
    run_frame(20, 1'b1, 0, 1'b0, 1000, 0);

    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
